mul_seq_8bit: RTL and testbench

//  Sequential shift-add 8x8 unsigned multiplier; one partial product per clock.

---
 rtl/mul_pkg.sv | 6 +
 rtl/fullAdder_8bit.sv | 10 +
 rtl/mul_seq_8bit.sv | 58 +++++
 tb/tb_mul_seq_8bit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and iteration constants for the sequential multiplier
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int MUL_ITER = 8;
  localparam int MUL_LAST = MUL_ITER - 1;
endpackage

// File: rtl/fullAdder_8bit.sv
// fullAdder_8bit: 8-bit ripple adder with carry in/out used for partial-product accumulation
module fullAdder_8bit (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {8'b0, cin};
endmodule

// File: rtl/mul_seq_8bit.sv
// mul_seq_8bit: shift-add 8x8 unsigned multiplier, one partial product per clock (optional MUL_EARLY_EXIT_EN skips zero operands)
module mul_seq_8bit
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand, mplr, acc_hi, sum, addend;
  logic [CNT_W-1:0] cnt;
  logic cout, accept, zero_op, last;
  assign accept = start && (state != RUN);
  assign last = cnt == CNT_W'(MUL_LAST);
`ifdef MUL_EARLY_EXIT_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif
  assign addend = mplr[0] ? mcand : '0;
  fullAdder_8bit u_add (.x(acc_hi), .y(addend), .cin(1'b0), .sum(sum), .cout(cout));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: new ops accepted from IDLE or DONE, RUN lasts exactly MUL_ITER edges
  always_comb begin
    state_nx = accept ? (zero_op ? DONE : RUN) : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  // operand capture and one shift-add step per RUN cycle; product held otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand  <= '0;
      mplr   <= '0;
      acc_hi <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= a;
      mplr   <= zero_op ? '0 : b;
      acc_hi <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc_hi <= {cout, sum[WIDTH-1:1]};
      mplr   <= {sum[0], mplr[WIDTH-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end
  assign busy = state == RUN;
  assign done = state == DONE;
  assign product = {acc_hi, mplr};
endmodule

// File: tb/tb_mul_seq_8bit.sv
// tb_mul_seq_8bit: randomized self-checking bench for mul_seq_8bit against an arithmetic model
module tb_mul_seq_8bit;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] a = 0, b = 0;
  logic busy, done;
  logic [15:0] product;
  int checks = 0, errors = 0;

  mul_seq_8bit dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                    .busy(busy), .done(done), .product(product));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef MUL_EARLY_EXIT_EN
    return (x == 0 || y == 0) ? 0 : 8;
`else
    return 8;
`endif
  endfunction

  // issue one op from a non-busy cycle; lat counts edges after the accepting edge until done
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, output int lat, output int bc);
    a = x; b = y; start = 1;
    tick();
    start = 0;
    lat = 0; bc = 0;
    while (!done && lat < 30) begin
      if (busy) bc++;
      a = 8'($urandom); b = 8'($urandom);
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1; tick(); tick(); rst = 0; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", product); end
  endtask

  task automatic test_basic;
    int lat, bc;
    do_op(8'd13, 8'd11, lat, bc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    checks++; if (product !== 16'h008F) begin errors++; $display("FAIL basic_product got %h want 008f", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (product !== 16'h008F) begin errors++; $display("FAIL basic_product_hold got %h want 008f", product); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    do_op(8'hFF, 8'hFF, lat, bc);
    checks++; if (product !== 16'hFE01) begin errors++; $display("FAIL b2b_first got %h want fe01", product); end
    do_op(8'd2, 8'd3, lat, bc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency got %0d want 8", lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 8", bc); end
    checks++; if (product !== 16'h0006) begin errors++; $display("FAIL b2b_second got %h want 0006", product); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %b want 0", done); end
  endtask

  task automatic test_ignore_start;
    int lat;
    a = 8'd5; b = 8'd7; start = 1;
    tick();
    start = 0; lat = 0;
    repeat (3) begin tick(); lat++; end
    a = 8'd9; b = 8'd9; start = 1;
    tick(); lat++;
    start = 0;
    while (!done && lat < 30) begin tick(); lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", lat); end
    checks++; if (product !== 16'h0023) begin errors++; $display("FAIL ignore_product got %h want 0023", product); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    a = 8'd200; b = 8'd99; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    rst = 1;
    #1;
    checks++; if ({busy, done, product} !== 18'h0) begin errors++; $display("FAIL midrst_outputs got busy=%b done=%b product=%h want 0 0 0000", busy, done, product); end
    tick(); rst = 0;
    seen = 0;
    repeat (12) begin tick(); if (done || busy) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen); end
  endtask

  task automatic test_zero_operand;
    int lat, bc;
    do_op(8'd0, 8'h80, lat, bc);
    checks++; if (lat !== exp_lat(8'd0, 8'h80)) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, exp_lat(8'd0, 8'h80)); end
    checks++; if (bc !== exp_lat(8'd0, 8'h80)) begin errors++; $display("FAIL zero_busy got %0d want %0d", bc, exp_lat(8'd0, 8'h80)); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL zero_product got %h want 0000", product); end
    tick();
  endtask

  task automatic test_random;
    int lat, bc;
    logic [7:0] x, y;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      if (i % 10 == 3) x = 0;
      if (i % 10 == 7) y = 0;
      do_op(x, y, lat, bc);
      checks++; if (product !== 16'(x) * 16'(y)) begin errors++; $display("FAIL rand_product %0d*%0d got %h want %h", x, y, product, 16'(x) * 16'(y)); end
      checks++; if (lat !== exp_lat(x, y)) begin errors++; $display("FAIL rand_latency %0d*%0d got %0d want %0d", x, y, lat, exp_lat(x, y)); end
      if ($urandom_range(1, 0) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    tick();
    test_ignore_start();
    test_reset_mid_run();
    test_zero_operand();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
